// File: rtl/display_scan_mux.sv
// Six-digit 7-segment scanner: one shared SEG bus, one-hot DIGIT enables, blank lead-in per slot.
// Optional COLON_BLINK_EN adds a DP output that blinks on the SEC10/MIN10 slots.
module display_scan_mux #(
   parameter int unsigned SCAN_DIV         = 1000,
   parameter int unsigned BLANK_CYC        = 50,
   parameter logic [6:0]  SEG_OFF          = 7'h7F,
   parameter bit          DIGIT_ACTIVE_LOW = 1'b0,
   parameter int unsigned BLINK_FRAMES     = 83
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] SEC1,
   input  logic [6:0] SEC10,
   input  logic [6:0] MIN1,
   input  logic [6:0] MIN10,
   input  logic [6:0] HOUR1,
   input  logic [6:0] HOUR10,
   output logic [6:0] SEG,
   output logic [5:0] DIGIT
`ifdef COLON_BLINK_EN
   ,
   output logic       DP
`endif
);

   localparam int unsigned CW        = $clog2(SCAN_DIV);
   localparam logic [5:0]  DIGIT_OFF = DIGIT_ACTIVE_LOW ? 6'h3F : 6'h00;

   typedef enum logic {StBlank, StDrive} phase_e;
   // With no blank interval the slot is driven from its very first cycle, including after reset.
   localparam phase_e PHASE_RST = (BLANK_CYC == 0) ? StDrive : StBlank;

   if (SCAN_DIV < 2) begin : g_bad_div
      $error("SCAN_DIV must be at least 2");
   end
   if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
      $error("BLANK_CYC must be below SCAN_DIV");
   end
   if (BLINK_FRAMES < 1) begin : g_bad_frames
      $error("BLINK_FRAMES must be at least 1");
   end

   logic [CW-1:0] cyc;
   logic [2:0]    idx;
   phase_e        phase;
   logic [6:0]    snap [6];

   logic          slot_end;
   logic          frame_start;
   logic [CW-1:0] cyc_nxt;
   logic [6:0]    cur_pat;
   logic [5:0]    onehot;

   assign slot_end    = (cyc == CW'(SCAN_DIV - 1));
   assign frame_start = (cyc == '0) && (idx == 3'd0);
   assign cyc_nxt     = slot_end ? '0 : cyc + CW'(1);
   assign onehot      = 6'b000001 << idx;

   // On the snapshot edge slot 0 shows the pattern being captured, not the stale one.
   always_comb begin
      cur_pat = SEG_OFF;
      case (idx)
         3'd0:    cur_pat = frame_start ? SEC1 : snap[0];
         3'd1:    cur_pat = snap[1];
         3'd2:    cur_pat = snap[2];
         3'd3:    cur_pat = snap[3];
         3'd4:    cur_pat = snap[4];
         3'd5:    cur_pat = snap[5];
         default: cur_pat = SEG_OFF;
      endcase
   end

`ifdef COLON_BLINK_EN
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FW-1:0] frame_cnt;
   logic          blink;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc   <= '0;
         idx   <= 3'd0;
         phase <= PHASE_RST;
         SEG   <= SEG_OFF;
         DIGIT <= DIGIT_OFF;
         for (int i = 0; i < 6; i++) snap[i] <= SEG_OFF;
`ifdef COLON_BLINK_EN
         frame_cnt <= '0;
         blink     <= 1'b0;
         DP        <= 1'b0;
`endif
      end else begin
         cyc <= cyc_nxt;
         if (slot_end) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;

         case (phase)
            StBlank: if (cyc_nxt == CW'(BLANK_CYC)) phase <= StDrive;
            StDrive: if (slot_end && (BLANK_CYC != 0)) phase <= StBlank;
            default: phase <= PHASE_RST;
         endcase

         // SEG and DIGIT move together from one stage so a lit digit never sees a SEG change.
         if (phase == StDrive) begin
            SEG   <= cur_pat;
            DIGIT <= DIGIT_ACTIVE_LOW ? ~onehot : onehot;
         end else begin
            SEG   <= SEG_OFF;
            DIGIT <= DIGIT_OFF;
         end

         if (frame_start) begin
            snap[0] <= SEC1;
            snap[1] <= SEC10;
            snap[2] <= MIN1;
            snap[3] <= MIN10;
            snap[4] <= HOUR1;
            snap[5] <= HOUR10;
         end

`ifdef COLON_BLINK_EN
         if (slot_end && (idx == 3'd5)) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt <= '0;
               blink     <= ~blink;
            end else begin
               frame_cnt <= frame_cnt + FW'(1);
            end
         end
         DP <= (phase == StDrive) && ((idx == 3'd1) || (idx == 3'd3)) && blink;
`endif
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: scoreboard against a cycle model plus table and hand sequences.
`timescale 1ns/1ps
module tb_display_scan_mux;

   localparam int unsigned SD = 8;
   localparam int unsigned BC = 2;
   localparam int unsigned BF = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] sec1, sec10, min1, min10, hour1, hour10;
   logic [6:0] seg_a, seg_b;
   logic [5:0] digit_a, digit_b;
`ifdef COLON_BLINK_EN
   logic       dp_a, dp_b;
`endif

   always #5 clk = ~clk;

   display_scan_mux #(
      .SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_OFF(7'h7F), .DIGIT_ACTIVE_LOW(1'b0), .BLINK_FRAMES(BF)
   ) u_dut_a (
      .clk(clk), .rst(rst), .SEC1(sec1), .SEC10(sec10), .MIN1(min1), .MIN10(min10),
      .HOUR1(hour1), .HOUR10(hour10), .SEG(seg_a), .DIGIT(digit_a)
`ifdef COLON_BLINK_EN
      , .DP(dp_a)
`endif
   );

   display_scan_mux #(
      .SCAN_DIV(SD), .BLANK_CYC(0), .SEG_OFF(7'h7F), .DIGIT_ACTIVE_LOW(1'b1), .BLINK_FRAMES(BF)
   ) u_dut_b (
      .clk(clk), .rst(rst), .SEC1(sec1), .SEC10(sec10), .MIN1(min1), .MIN10(min10),
      .HOUR1(hour1), .HOUR10(hour10), .SEG(seg_b), .DIGIT(digit_b)
`ifdef COLON_BLINK_EN
      , .DP(dp_b)
`endif
   );

   typedef struct {
      logic [6:0] seg;
      logic [5:0] digit;
      logic       dp;
   } exp_t;

   typedef struct {
      int unsigned edge_n;
      logic [6:0]  seg;
      logic [5:0]  digit;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t sb_q[$];

   // Cycle model of unit A and a closed-form model of unit B (edges since release).
   int unsigned m_cyc, m_idx, m_frame;
   logic        m_blink;
   logic [6:0]  m_snap [6];
   int unsigned b_t;
   logic [6:0]  b_snap [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] in_pat(input int i);
      case (i)
         0:       return sec1;
         1:       return sec10;
         2:       return min1;
         3:       return min10;
         4:       return hour1;
         default: return hour10;
      endcase
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_idx = 0; m_frame = 0; m_blink = 1'b0; b_t = 0;
      for (int i = 0; i < 6; i++) begin
         m_snap[i] = 7'h7F;
         b_snap[i] = 7'h7F;
      end
      sb_q.delete();
   endtask

   task automatic tick();
      exp_t        e;
      logic [6:0]  b_seg_exp;
      logic [5:0]  b_dig_exp;
      int unsigned b_cyc, b_idx;
      if (m_cyc < BC) begin
         e.seg = 7'h7F; e.digit = 6'b0; e.dp = 1'b0;
      end else begin
         e.seg   = m_snap[m_idx];
         e.digit = 6'b000001 << m_idx;
         e.dp    = ((m_idx == 1) || (m_idx == 3)) && m_blink;
      end
      sb_q.push_back(e);
      b_cyc = b_t % SD;
      b_idx = (b_t / SD) % 6;
      if (b_t % (6 * SD) == 0)
         for (int i = 0; i < 6; i++) b_snap[i] = in_pat(i);
      b_dig_exp = ~(6'b000001 << b_idx);
      b_seg_exp = b_snap[b_idx];
      @(posedge clk);
      #1;
      if (m_cyc == 0 && m_idx == 0)
         for (int i = 0; i < 6; i++) m_snap[i] = in_pat(i);
      if (m_cyc == SD - 1) begin
         m_cyc = 0;
         if (m_idx == 5) begin
            m_idx = 0;
            if (m_frame == BF - 1) begin
               m_frame = 0;
               m_blink = ~m_blink;
            end else begin
               m_frame++;
            end
         end else begin
            m_idx++;
         end
      end else begin
         m_cyc++;
      end
      b_t++;
      e = sb_q.pop_front();
      chk("sb_seg", seg_a, e.seg);
      chk("sb_digit", digit_a, e.digit);
`ifdef COLON_BLINK_EN
      chk("sb_dp", dp_a, e.dp);
`endif
      chk("b_digit", digit_b, b_dig_exp);
      if (b_cyc != 0) chk("b_seg", seg_b, b_seg_exp);
   endtask

   task automatic run_until_digit(input logic [5:0] d, input string name);
      int n = 0;
      while (digit_a !== d && n < 200) begin
         tick();
         n++;
      end
      if (digit_a !== d) chk(name, digit_a, d);
   endtask

   vec_t vec [9];
   int   act_cnt [6];
   int   dp_cnt [4];

   initial begin
      vec[0] = '{1, 7'h7F, 6'b000000};
      vec[1] = '{2, 7'h7F, 6'b000000};
      vec[2] = '{3, 7'h01, 6'b000001};
      vec[3] = '{4, 7'h01, 6'b000001};
      vec[4] = '{5, 7'h01, 6'b000001};
      vec[5] = '{6, 7'h01, 6'b000001};
      vec[6] = '{7, 7'h01, 6'b000001};
      vec[7] = '{8, 7'h01, 6'b000001};
      vec[8] = '{9, 7'h7F, 6'b000000};

      sec1 = 7'h01; sec10 = 7'h02; min1 = 7'h03; min10 = 7'h04; hour1 = 7'h05; hour10 = 7'h06;
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_seg", seg_a, 7'h7F);
      chk("rst_digit", digit_a, 6'b0);
      chk("rst_digit_b", digit_b, 6'h3F);
`ifdef COLON_BLINK_EN
      chk("rst_dp", dp_a, 1'b0);
`endif
      rst = 1'b1;

      // Startup sequence after release
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("t1_seg_e%0d", vec[i].edge_n), seg_a, vec[i].seg);
         chk($sformatf("t1_digit_e%0d", vec[i].edge_n), digit_a, vec[i].digit);
      end

      // One full frame period: each digit lit for SD-BC edges
      for (int k = 0; k < 6; k++) act_cnt[k] = 0;
      for (int n = 0; n < 6 * SD; n++) begin
         tick();
         for (int k = 0; k < 6; k++) if (digit_a[k]) act_cnt[k]++;
      end
      for (int k = 0; k < 6; k++) chk($sformatf("t2_active_bit%0d", k), act_cnt[k], SD - BC);

      // Input change mid-frame must wait for the next frame's snapshot
      begin
         int n = 0;
         while (m_idx != 1 && n < 100) begin
            tick();
            n++;
         end
         chk("t3_reach_idx1", m_idx, 1);
      end
      min1 = 7'h40;
      run_until_digit(6'b000100, "t3_wait_idx2");
      chk("t3_same_frame", seg_a, 7'h03);
      run_until_digit(6'b100000, "t3_wait_idx5");
      run_until_digit(6'b000100, "t3_wait_next_idx2");
      chk("t3_next_frame", seg_a, 7'h40);

      // Asynchronous reset while digit 3 is lit
      run_until_digit(6'b001000, "t4_wait_idx3");
      #2;
      rst = 1'b0;
      #1;
      chk("t4_async_digit", digit_a, 6'b0);
      chk("t4_async_seg", seg_a, 7'h7F);
      chk("t4_async_digit_b", digit_b, 6'h3F);
      @(posedge clk);
      #1;
      chk("t4_hold_digit", digit_a, 6'b0);
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("t4_seg_e%0d", vec[i].edge_n), seg_a, vec[i].seg);
         chk($sformatf("t4_digit_e%0d", vec[i].edge_n), digit_a, vec[i].digit);
      end

      // Run four frames from this release; DP counts per frame
      for (int f = 0; f < 4; f++) dp_cnt[f] = 0;
      while (b_t < 4 * 6 * SD) begin
         int unsigned t_pre;
         t_pre = b_t;
         tick();
`ifdef COLON_BLINK_EN
         if (dp_a === 1'b1) dp_cnt[t_pre / (6 * SD)]++;
`else
         if (t_pre == 0) dp_cnt[0] = 0;
`endif
      end
`ifdef COLON_BLINK_EN
      chk("t6_dp_frame0", dp_cnt[0], 0);
      chk("t6_dp_frame1", dp_cnt[1], 0);
      chk("t6_dp_frame2", dp_cnt[2], 2 * (SD - BC));
      chk("t6_dp_frame3", dp_cnt[3], 2 * (SD - BC));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
